pwm_duty_meter: RTL

- Receive-side counterpart of the team's PWM generator.
- Samples an external PWM waveform, measures high time and period in clk cycles, and reduces the duty cycle to a 3-bit code in the same units as the generator's speed[2:0] input.
- Sits behind a Tiny Tapeout top-level input pin.
- Output feeds loopback self-test and a closed-loop speed readback.

---
 rtl/pwm_duty_meter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures high time and period of a sampled PWM input and reduces the duty cycle to a 3-bit code
module pwm_duty_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_width,
    output logic [CNT_W-1:0] period,
    output logic [2:0]       duty_code,
    output logic             meas_valid,
    output logic             stuck,
    output logic             overrun
);
    localparam logic [CNT_W-1:0] MAX  = '1;
    localparam logic [CNT_W-1:0] NEAR = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_prev_q, rise;
    logic [CNT_W-1:0]       pcnt_q, pcnt_d, hcnt_q, hcnt_d, h_q, p_q;
    logic [CNT_W-1:0]       hw_q, per_q;
    logic [CNT_W:0]         rem_q, rem_d, rem_sh;
    logic [2:0]             q_q, q_d, code_q;
    logic [1:0]             step_q;
    logic                   armed_q, tmo_q, overrun_q, stuck_q;
    logic                   capture, drop, tmo_fire, div_last, ge;

    always_comb begin
        s        = sync_q[SYNC_STAGES-1];
        rise     = s & ~s_prev_q;
        capture  = enable & rise & armed_q & (state_q == IDLE);
        drop     = enable & rise & armed_q & (state_q != IDLE);
        // Fires on the step into saturation, so it happens once per silent stretch
        tmo_fire = enable & ~rise & (pcnt_q == NEAR);
        pcnt_d   = !enable ? '0 : rise ? ONE : (pcnt_q == MAX) ? pcnt_q : pcnt_q + ONE;
        hcnt_d   = !enable ? '0 : rise ? ONE : (s && hcnt_q != MAX) ? hcnt_q + ONE : hcnt_q;
        rem_sh   = {rem_q[CNT_W-1:0], 1'b0};
        ge       = rem_sh >= {1'b0, p_q};
        rem_d    = ge ? rem_sh - {1'b0, p_q} : rem_sh;
        q_d      = {q_q[1:0], ge};
        div_last = (state_q == DIV) && (step_q == 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = !enable              ? IDLE :
                  capture              ? DIV  :
                  div_last             ? DONE :
                  (state_q == DONE)    ? IDLE : state_q;
    end

    always_comb begin
        meas_valid = enable & ((state_q == DONE) | tmo_q);
        overrun    = enable & overrun_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            s_prev_q  <= 1'b0;
            pcnt_q    <= '0;
            hcnt_q    <= '0;
            armed_q   <= 1'b0;
            overrun_q <= 1'b0;
            tmo_q     <= 1'b0;
            h_q       <= '0;
            p_q       <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            step_q    <= '0;
            hw_q      <= '0;
            per_q     <= '0;
            code_q    <= '0;
            stuck_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_prev_q  <= s;
            pcnt_q    <= pcnt_d;
            hcnt_q    <= hcnt_d;
            armed_q   <= enable & ~tmo_fire & (armed_q | rise);
            overrun_q <= drop;
            tmo_q     <= tmo_fire;
            if (capture) begin
                h_q    <= hcnt_q;
                p_q    <= pcnt_q;
                rem_q  <= {1'b0, hcnt_q};
                q_q    <= '0;
                step_q <= '0;
            end else if (state_q == DIV) begin
                rem_q  <= rem_d;
                q_q    <= q_d;
                step_q <= step_q + 2'd1;
            end
            // Results land as DONE begins so they are stable while meas_valid is high
            if (enable && div_last) begin
                hw_q    <= h_q;
                per_q   <= p_q;
                code_q  <= q_d;
                stuck_q <= 1'b0;
            end else if (tmo_fire) begin
                hw_q    <= s ? MAX : '0;
                per_q   <= MAX;
                code_q  <= s ? 3'd7 : 3'd0;
                stuck_q <= 1'b1;
            end
        end
    end

    assign high_width = hw_q;
    assign period     = per_q;
    assign duty_code  = code_q;
    assign stuck      = stuck_q;
endmodule
